// File: rtl/quadrature_step_decoder.sv
// quadrature_step_decoder: sync+debounce raw A/B encoder lines, decode Gray steps into step/up_down, flag and count illegal jumps
//   clk       in  system clock, rising edge
//   rst       in  asynchronous active-low reset
//   enc_a     in  raw encoder channel A (asynchronous)
//   enc_b     in  raw encoder channel B (asynchronous)
//   err_clr   in  synchronous clear of err_flag/err_count (wins over a coincident error)
//   step      out one-cycle pulse per legal quadrature edge
//   up_down   out direction of last legal step, 1 = up
//   err_flag  out sticky illegal-transition flag
//   err_count out saturating illegal-transition count
module quadrature_step_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ERR_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count
);
  localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PRIME = SYNC_STAGES + DEBOUNCE_CYCLES + 2;
  localparam int PW    = $clog2(PRIME + 1);
  logic [1:0] raw, filt, prev, chg;
  logic [PW-1:0] pcnt;
  logic primed;
  assign raw = {enc_a, enc_b};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] s;
    logic [CW-1:0] n;
    logic f;
    assign filt[c] = f;
    // the filtered bit reloads one cycle after the run counter hits the limit
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        s <= '0;
        n <= '0;
        f <= 1'b0;
      end else begin
        s <= {s[SYNC_STAGES-2:0], raw[c]};
        if (n == CW'(DEBOUNCE_CYCLES)) begin
          f <= s[SYNC_STAGES-1];
          n <= '0;
        end else begin
          n <= (s[SYNC_STAGES-1] != f) ? n + CW'(1) : '0;
        end
      end
  end
  // filtered loads that happen before the first possible debounced update has settled are not decoded
  assign primed = pcnt == PW'(PRIME);
  assign chg = filt ^ prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pcnt      <= '0;
      prev      <= 2'b00;
      step      <= 1'b0;
      up_down   <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      if (!primed) pcnt <= pcnt + PW'(1);
      prev <= filt;
      step <= primed && ^chg;
      // Gray order 00,01,11,10: moving up exactly when old A differs from new B
      if (primed && ^chg) up_down <= prev[1] ^ filt[0];
      if (err_clr) begin
        err_flag  <= 1'b0;
        err_count <= '0;
      end else if (primed && &chg) begin
        err_flag <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
      end
    end
endmodule

// File: tb/tb_quadrature_step_decoder.sv
// tb_quadrature_step_decoder: randomized and directed checks of the quadrature decoder against a pin-history model
module tb_quadrature_step_decoder;
  localparam int S = 2;
  localparam int D = 4;
  localparam int P = S + D + 2;
  logic clk = 0;
  logic rst = 1;
  logic enc_a = 0;
  logic enc_b = 0;
  logic err_clr = 0;
  logic step, up_down, err_flag;
  logic [7:0] err_count;
  logic [10:0] obs;
  int checks = 0;
  int failures = 0;
  int e, la, lb, m_cnt;
  bit ha[$];
  bit hb[$];
  bit mfa, mfb, pfa, pfb, m_step, m_up, m_flag;
  bit [1:0] old_st, new_st;
  quadrature_step_decoder #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
    .step(step), .up_down(up_down), .err_flag(err_flag), .err_count(err_count)
  );
  assign obs = {step, up_down, err_flag, err_count};
  always #5 clk = ~clk;
  function automatic bit hist(input bit ch, input int i);
    if (i < 0) return 1'b0;
    return ch ? ha[i] : hb[i];
  endfunction
  // a pin flips its filtered value once it has held the opposite level for D+1 samples ending S edges ago,
  // and no sooner than D+1 edges after its previous flip
  function automatic bit flips(input bit ch, input bit f, input int last, input int t);
    if (t - last < D + 1) return 1'b0;
    for (int i = t - S - D; i <= t - S; i++) if (hist(ch, i) == f) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int pos(input bit [1:0] st);
    return st == 2'b00 ? 0 : st == 2'b01 ? 1 : st == 2'b11 ? 2 : 3;
  endfunction
  function automatic logic [10:0] expv();
    return {m_step, m_up, m_flag, 8'(m_cnt)};
  endfunction
  task automatic model_reset();
    e = 0; la = -100; lb = -100; m_cnt = 0;
    ha.delete(); hb.delete();
    mfa = 0; mfb = 0; pfa = 0; pfb = 0; m_step = 0; m_up = 0; m_flag = 0;
    old_st = 2'b00; new_st = 2'b00;
  endtask
  task automatic tick(input bit a, input bit b, input bit clr);
    bit fa_n, fb_n, pr;
    enc_a = a; enc_b = b; err_clr = clr;
    @(posedge clk);
    ha.push_back(a); hb.push_back(b);
    pr = e >= P;
    m_step = pr && (pfa ^ pfb);
    if (m_step) m_up = pos(new_st) == (pos(old_st) + 1) % 4;
    if (clr) begin
      m_flag = 0; m_cnt = 0;
    end else if (pr && pfa && pfb) begin
      m_flag = 1;
      if (m_cnt < 255) m_cnt++;
    end
    fa_n = flips(1, mfa, la, e);
    fb_n = flips(0, mfb, lb, e);
    old_st = {mfa, mfb};
    if (fa_n) begin mfa = !mfa; la = e; end
    if (fb_n) begin mfb = !mfb; lb = e; end
    new_st = {mfa, mfb};
    pfa = fa_n; pfb = fb_n;
    e++;
    @(negedge clk);
  endtask
  task automatic test_reset();
    #2 rst = 0;
    repeat (3) @(negedge clk);
    if (obs !== 11'd0) begin failures++; $display("FAIL reset_hold got=%b want=0", obs); end
    checks++;
    rst = 1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0);
      if (obs !== expv()) begin failures++; $display("FAIL reset_idle e=%0d got=%b want=%b", e, obs, expv()); end
      checks++;
    end
  endtask
  task automatic test_up();
    bit [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int n = 0;
    for (int k = 0; k < 4; k++) begin
      int at = -1;
      for (int i = 0; i < 10; i++) begin
        tick(seq[k][1], seq[k][0], 0);
        if (obs !== expv()) begin failures++; $display("FAIL up_seq e=%0d got=%b want=%b", e, obs, expv()); end
        checks++;
        if (step) begin n++; at = i; end
      end
      if (at !== 7) begin failures++; $display("FAIL up_latency got=%0d want=7", at); end
      checks++;
      if (up_down !== 1'b1) begin failures++; $display("FAIL up_dir got=%b want=1", up_down); end
      checks++;
    end
    if (n !== 4) begin failures++; $display("FAIL up_count got=%0d want=4", n); end
    checks++;
  endtask
  task automatic test_down();
    bit [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int n = 0;
    for (int k = 0; k < 4; k++) begin
      int at = -1;
      for (int i = 0; i < 10; i++) begin
        tick(seq[k][1], seq[k][0], 0);
        if (obs !== expv()) begin failures++; $display("FAIL down_seq e=%0d got=%b want=%b", e, obs, expv()); end
        checks++;
        if (step) begin n++; at = i; end
      end
      if (at !== 7 || up_down !== 1'b0) begin failures++; $display("FAIL down_step at=%0d dir=%b want 7 0", at, up_down); end
      checks++;
    end
    if (n !== 4 || err_count !== 8'd0) begin failures++; $display("FAIL down_count steps=%0d err=%0d want 4 0", n, err_count); end
    checks++;
  endtask
  task automatic test_glitch();
    int n = 0;
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      tick(i >= 3, 0, 0);
      if (obs !== expv()) begin failures++; $display("FAIL glitch e=%0d got=%b want=%b", e, obs, expv()); end
      checks++;
      if (step) n++;
    end
    if (n !== 0 || err_flag !== 1'b0) begin failures++; $display("FAIL glitch_quiet steps=%0d flag=%b want 0 0", n, err_flag); end
    checks++;
  endtask
  task automatic test_illegal();
    int n = 0;
    for (int i = 0; i < 10; i++) tick(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 0);
      if (obs !== expv()) begin failures++; $display("FAIL illegal e=%0d got=%b want=%b", e, obs, expv()); end
      checks++;
      if (step) n++;
    end
    if (n !== 0 || err_flag !== 1'b1 || err_count !== 8'd1) begin
      failures++; $display("FAIL illegal_flag steps=%0d flag=%b cnt=%0d want 0 1 1", n, err_flag, err_count);
    end
    checks++;
    tick(1, 1, 1);
    if (err_flag !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL err_clr flag=%b cnt=%0d want 0 0", err_flag, err_count); end
    checks++;
  endtask
  task automatic test_saturate();
    int n = 0;
    for (int k = 0; k < 300; k++)
      for (int i = 0; i < 6; i++) begin
        tick(k % 2 == 0 ? 1'b0 : 1'b1, k % 2 == 0 ? 1'b0 : 1'b1, 0);
        if (obs !== expv()) begin failures++; $display("FAIL saturate e=%0d got=%b want=%b", e, obs, expv()); end
        checks++;
        if (step) n++;
      end
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    if (n !== 0 || err_count !== 8'd255 || err_flag !== 1'b1) begin
      failures++; $display("FAIL saturate_end steps=%0d cnt=%0d flag=%b want 0 255 1", n, err_count, err_flag);
    end
    checks++;
    for (int i = 0; i < 12; i++) tick(1, 1, 1);
    if (err_count !== 8'd0 || err_flag !== 1'b0) begin failures++; $display("FAIL clr_wins cnt=%0d flag=%b want 0 0", err_count, err_flag); end
    checks++;
  endtask
  task automatic test_random();
    bit a = 1, b = 1;
    int hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        a = 1'($urandom); b = 1'($urandom); hold = $urandom_range(1, 8);
      end
      hold--;
      tick(a, b, $urandom_range(0, 19) == 0);
      if (obs !== expv()) begin failures++; $display("FAIL random e=%0d got=%b want=%b", e, obs, expv()); end
      checks++;
    end
  endtask
  task automatic test_prime_reset();
    int n = 0;
    bit seen = 0;
    enc_a = 1; enc_b = 1;
    #3 rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1, 1, 0);
      if (obs !== expv()) begin failures++; $display("FAIL prime e=%0d got=%b want=%b", e, obs, expv()); end
      checks++;
      if (step || err_flag) n++;
    end
    if (n !== 0) begin failures++; $display("FAIL prime_quiet events=%0d want 0", n); end
    checks++;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1, 0, 0);
      seen = m_step;
    end
    if (!seen || obs !== expv()) begin failures++; $display("FAIL prime_step seen=%b got=%b want=%b", seen, obs, expv()); end
    checks++;
    #1 rst = 0;
    #1;
    if (obs !== 11'd0) begin failures++; $display("FAIL async_reset got=%b want=0", obs); end
    checks++;
    repeat (3) @(negedge clk);
    if (obs !== 11'd0) begin failures++; $display("FAIL reset_held got=%b want=0", obs); end
    checks++;
    rst = 1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      if (obs !== expv()) begin failures++; $display("FAIL reprime e=%0d got=%b want=%b", e, obs, expv()); end
      checks++;
    end
  endtask
  initial begin
    test_reset();
    test_up();
    test_down();
    test_glitch();
    test_illegal();
    test_saturate();
    test_random();
    test_prime_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
